// File: rtl/atm_keypad_pkg.sv
// Shared key codes, FSM state encodings and widths for the ATM front-panel transmitter.
package atm_keypad_pkg;

  localparam int unsigned AMOUNT_W = 32;

  localparam logic [3:0] KEY_WITHDRAW = 4'hA;
  localparam logic [3:0] KEY_DEPOSIT  = 4'hB;
  localparam logic [3:0] KEY_CLEAR    = 4'hC;
  localparam logic [3:0] KEY_ENTER    = 4'hE;

  typedef enum logic [2:0] {
    IDLE,
    PIN,
    SELECT,
    AMOUNT,
    RESULT,
    LOCKED
  } state_t;

  typedef enum logic {
    DEB_ARMED,
    DEB_RELEASE
  } deb_state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/atm_key_debounce.sv
// Keypad debouncer: one keyEvent pulse per stable press, re-armed only after a stable release.
module atm_key_debounce
  import atm_keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       keyPressed,
  input  logic [3:0] keyCode,
  output logic       keyEvent,
  output logic [3:0] keyValue
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  deb_state_t    phase, phase_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          accepted, accept_n;

  always_comb begin
    phase_n  = phase;
    cnt_n    = cnt;
    accept_n = 1'b0;
    case (phase)
      DEB_ARMED: begin
        if (keyPressed) begin
          if (cnt == LAST) begin
            accept_n = 1'b1;
            phase_n  = DEB_RELEASE;
            cnt_n    = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end else begin
          cnt_n = '0;
        end
      end
      DEB_RELEASE: begin
        if (!keyPressed) begin
          if (cnt == LAST) begin
            phase_n = DEB_ARMED;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end else begin
          cnt_n = '0;
        end
      end
      default: phase_n = DEB_RELEASE;
    endcase
  end

  // Reset lands in DEB_RELEASE so a key held through reset must first be released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase    <= DEB_RELEASE;
      cnt      <= '0;
      accepted <= 1'b0;
      keyEvent <= 1'b0;
      keyValue <= '0;
    end else begin
      phase    <= phase_n;
      cnt      <= cnt_n;
      accepted <= accept_n;
      keyEvent <= accepted;
      if (accept_n) keyValue <= keyCode;
    end
  end

endmodule

// File: rtl/atm_keypad_tx.sv
// ATM front-panel transmitter: session FSM turning debounced keys into controller strobes.
module atm_keypad_tx
  import atm_keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PIN_DIGITS      = 4,
  parameter int unsigned AMOUNT_DIGITS   = 9
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cardPresent,
  input  logic                keyPressed,
  input  logic [3:0]          keyCode,
  input  logic                incorrectPin,
  input  logic                warning,
  input  logic                block,
  input  logic                balanceUpdated,
  input  logic                insufficientFunds,
  output logic                stbDigit,
  output logic [3:0]          digit,
  output logic                stbTransaction,
  output logic                transType,
  output logic                stbAmount,
  output logic [AMOUNT_W-1:0] amount,
  output logic                panelLocked
);

  localparam int unsigned PW = $clog2(PIN_DIGITS + 1);
  localparam int unsigned AW = $clog2(AMOUNT_DIGITS + 1);

  state_t              state, state_n;
  logic [PW-1:0]       pin_count, pin_count_n;
  logic [AW-1:0]       amt_count, amt_count_n;
  logic [AMOUNT_W-1:0] acc, acc_n, amount_n;
  logic                stb_digit_n, stb_trans_n, stb_amount_n, trans_type_n;
  logic [3:0]          digit_n;
  logic                ip_q, warn_q, blk_q;
  logic                ip_rise, warn_rise, blk_rise;
  logic                key_event;
  logic [3:0]          key_value;

  atm_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clock     (clock),
    .reset     (reset),
    .keyPressed(keyPressed),
    .keyCode   (keyCode),
    .keyEvent  (key_event),
    .keyValue  (key_value)
  );

  assign ip_rise     = incorrectPin & ~ip_q;
  assign warn_rise   = warning & ~warn_q;
  assign blk_rise    = block & ~blk_q;
  assign panelLocked = (state == LOCKED);

  always_comb begin
    state_n      = state;
    pin_count_n  = pin_count;
    amt_count_n  = amt_count;
    acc_n        = acc;
    amount_n     = amount;
    digit_n      = digit;
    trans_type_n = transType;
    stb_digit_n  = 1'b0;
    stb_trans_n  = 1'b0;
    stb_amount_n = 1'b0;
    // Priority: card removal, then leaving IDLE, then block, then per-state handling.
    if (!cardPresent) begin
      state_n     = IDLE;
      pin_count_n = '0;
      amt_count_n = '0;
      acc_n       = '0;
    end else if (state == IDLE) begin
      state_n     = PIN;
      pin_count_n = '0;
    end else if (blk_rise && state != LOCKED) begin
      state_n = LOCKED;
    end else begin
      case (state)
        PIN: begin
          if (key_event) begin
            if (is_digit(key_value)) begin
              stb_digit_n = 1'b1;
              digit_n     = key_value;
              pin_count_n = pin_count + PW'(1);
              if (pin_count_n == PW'(PIN_DIGITS)) state_n = SELECT;
            end else if (key_value == KEY_CLEAR) begin
              pin_count_n = '0;
            end
          end
        end
        SELECT: begin
          if (ip_rise || warn_rise) begin
            state_n     = PIN;
            pin_count_n = '0;
          end else if (key_event) begin
            if (key_value == KEY_WITHDRAW || key_value == KEY_DEPOSIT) begin
              trans_type_n = (key_value == KEY_WITHDRAW);
              stb_trans_n  = 1'b1;
              state_n      = AMOUNT;
              acc_n        = '0;
              amt_count_n  = '0;
            end else if (is_digit(key_value)) begin
              stb_digit_n = 1'b1;
              digit_n     = key_value;
              pin_count_n = PW'(1);
              state_n     = PIN;
            end
          end
        end
        AMOUNT: begin
          if (key_event) begin
            if (is_digit(key_value)) begin
              if (amt_count != AW'(AMOUNT_DIGITS)) begin
                acc_n       = acc * AMOUNT_W'(10) + AMOUNT_W'(key_value);
                amt_count_n = amt_count + AW'(1);
              end
            end else if (key_value == KEY_CLEAR) begin
              acc_n       = '0;
              amt_count_n = '0;
            end else if (key_value == KEY_ENTER && amt_count != '0) begin
              amount_n     = acc;
              stb_amount_n = 1'b1;
              state_n      = RESULT;
            end
          end
        end
        RESULT: begin
          if (balanceUpdated || insufficientFunds) begin
            state_n     = PIN;
            pin_count_n = '0;
            acc_n       = '0;
            amt_count_n = '0;
          end
        end
        LOCKED:  ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pin_count      <= '0;
      amt_count      <= '0;
      acc            <= '0;
      amount         <= '0;
      digit          <= '0;
      transType      <= 1'b0;
      stbDigit       <= 1'b0;
      stbTransaction <= 1'b0;
      stbAmount      <= 1'b0;
      ip_q           <= 1'b0;
      warn_q         <= 1'b0;
      blk_q          <= 1'b0;
    end else begin
      state          <= state_n;
      pin_count      <= pin_count_n;
      amt_count      <= amt_count_n;
      acc            <= acc_n;
      amount         <= amount_n;
      digit          <= digit_n;
      transType      <= trans_type_n;
      stbDigit       <= stb_digit_n;
      stbTransaction <= stb_trans_n;
      stbAmount      <= stb_amount_n;
      if (state == IDLE) begin
        ip_q   <= 1'b0;
        warn_q <= 1'b0;
        blk_q  <= 1'b0;
      end else begin
        ip_q   <= incorrectPin;
        warn_q <= warning;
        blk_q  <= block;
      end
    end
  end

endmodule

// File: tb/tb_atm_keypad_tx.sv
// Directed bench for atm_keypad_tx: key-sequence table plus hand-timed corner cases.
module tb_atm_keypad_tx;
  import atm_keypad_pkg::*;

  localparam int unsigned D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cardPresent = 1'b0;
  logic        keyPressed = 1'b0;
  logic [3:0]  keyCode = '0;
  logic        incorrectPin = 1'b0;
  logic        warning = 1'b0;
  logic        block = 1'b0;
  logic        balanceUpdated = 1'b0;
  logic        insufficientFunds = 1'b0;
  logic        stbDigit, stbTransaction, stbAmount, transType, panelLocked;
  logic [3:0]  digit;
  logic [31:0] amount;

  atm_keypad_tx #(.DEBOUNCE_CYCLES(D), .PIN_DIGITS(4), .AMOUNT_DIGITS(9)) dut (
    .clock(clock), .reset(reset), .cardPresent(cardPresent),
    .keyPressed(keyPressed), .keyCode(keyCode),
    .incorrectPin(incorrectPin), .warning(warning), .block(block),
    .balanceUpdated(balanceUpdated), .insufficientFunds(insufficientFunds),
    .stbDigit(stbDigit), .digit(digit), .stbTransaction(stbTransaction),
    .transType(transType), .stbAmount(stbAmount), .amount(amount),
    .panelLocked(panelLocked)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int n_dig = 0, n_tr = 0, n_amt = 0;
  logic [3:0] last_digit = '0;
  logic prev_any = 1'b0;

  typedef struct {
    logic [3:0]  key;
    int          kind;   // 0 none, 1 digit, 2 transaction, 3 amount
    logic [31:0] data;
    state_t      st;
  } vec_t;
  vec_t vecs[30];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (stbDigit) begin n_dig++; last_digit = digit; end
      if (stbTransaction) n_tr++;
      if (stbAmount) n_amt++;
      if (stbDigit || stbTransaction || stbAmount) begin
        total++;
        if ((int'(stbDigit) + int'(stbTransaction) + int'(stbAmount)) > 1 || prev_any) begin
          bad++;
          $display("FAIL strobe_excl: got %b%b%b prev=%b want one isolated strobe",
                   stbDigit, stbTransaction, stbAmount, prev_any);
        end
      end
      prev_any = stbDigit | stbTransaction | stbAmount;
    end else begin
      prev_any = 1'b0;
    end
  end

  task automatic press(input logic [3:0] k);
    keyCode = k;
    keyPressed = 1'b1;
    repeat (D + 4) @(negedge clock);
    keyPressed = 1'b0;
    repeat (D + 4) @(negedge clock);
  endtask

  task automatic press_check(input logic [3:0] k, input int kind, input logic [31:0] data,
                             input state_t st);
    n_dig = 0; n_tr = 0; n_amt = 0;
    press(k);
    check("n_digit", n_dig, (kind == 1) ? 1 : 0);
    check("n_trans", n_tr, (kind == 2) ? 1 : 0);
    check("n_amount", n_amt, (kind == 3) ? 1 : 0);
    if (kind == 1) check("digit", last_digit, data);
    if (kind == 2) check("transType", transType, data);
    if (kind == 3) check("amount", amount, data);
    check("state", dut.state, st);
  endtask

  initial begin
    int seen;
    logic [5:0] pat;

    vecs[0]  = '{4'd1, 1, 1, PIN};
    vecs[1]  = '{4'd2, 1, 2, PIN};
    vecs[2]  = '{4'd3, 1, 3, PIN};
    vecs[3]  = '{4'd4, 1, 4, SELECT};
    vecs[4]  = '{KEY_DEPOSIT, 2, 0, AMOUNT};
    vecs[5]  = '{4'd2, 0, 0, AMOUNT};
    vecs[6]  = '{4'd5, 0, 0, AMOUNT};
    vecs[7]  = '{4'd0, 0, 0, AMOUNT};
    vecs[8]  = '{KEY_CLEAR, 0, 0, AMOUNT};
    vecs[9]  = '{4'd1, 0, 0, AMOUNT};
    vecs[10] = '{4'd0, 0, 0, AMOUNT};
    vecs[11] = '{4'd0, 0, 0, AMOUNT};
    vecs[12] = '{KEY_ENTER, 3, 100, RESULT};
    vecs[13] = '{4'd1, 1, 1, PIN};
    vecs[14] = '{4'd2, 1, 2, PIN};
    vecs[15] = '{4'd3, 1, 3, PIN};
    vecs[16] = '{4'd4, 1, 4, SELECT};
    vecs[17] = '{KEY_WITHDRAW, 2, 1, AMOUNT};
    vecs[18] = '{KEY_ENTER, 0, 0, AMOUNT};
    for (int i = 19; i < 29; i++) vecs[i] = '{4'd9, 0, 0, AMOUNT};
    vecs[29] = '{KEY_ENTER, 3, 999999999, RESULT};

    // Reset state
    @(negedge clock);
    check("rst_stbDigit", stbDigit, 0);
    check("rst_stbTrans", stbTransaction, 0);
    check("rst_stbAmount", stbAmount, 0);
    check("rst_digit", digit, 0);
    check("rst_amount", amount, 0);
    check("rst_locked", panelLocked, 0);
    reset = 1'b0;
    repeat (D + 4) @(negedge clock);
    check("idle_no_card", dut.state, IDLE);
    cardPresent = 1'b1;
    repeat (2) @(negedge clock);
    check("card_to_pin", dut.state, PIN);

    // Bouncy press of key 7, then a long hold
    n_dig = 0; seen = -1; pat = 6'b111101; keyCode = 4'd7;
    for (int t = 0; t < 30; t++) begin
      if (stbDigit && seen < 0) seen = t;
      keyPressed = (t < 6) ? pat[t] : 1'b1;
      @(negedge clock);
    end
    check("bounce_latency", seen, 8);
    check("bounce_count", n_dig, 1);
    check("bounce_digit", last_digit, 7);
    keyPressed = 1'b0;
    repeat (D + 4) @(negedge clock);
    check("bounce_pincount", dut.pin_count, 1);
    press_check(KEY_CLEAR, 0, 0, PIN);
    check("clear_pincount", dut.pin_count, 0);

    // Table: PIN, deposit, amount 100
    for (int i = 0; i < 13; i++) press_check(vecs[i].key, vecs[i].kind, vecs[i].data, vecs[i].st);
    balanceUpdated = 1'b1;
    repeat (2) @(negedge clock);
    check("balance_to_pin", dut.state, PIN);
    balanceUpdated = 1'b0;

    // Table: withdraw, empty enter, ten nines
    for (int i = 13; i < 30; i++) press_check(vecs[i].key, vecs[i].kind, vecs[i].data, vecs[i].st);
    insufficientFunds = 1'b1;
    repeat (2) @(negedge clock);
    check("funds_to_pin", dut.state, PIN);
    insufficientFunds = 1'b0;

    // incorrectPin edge in SELECT, then retry with the flag held high
    for (int i = 0; i < 4; i++) press_check(vecs[i].key, vecs[i].kind, vecs[i].data, vecs[i].st);
    incorrectPin = 1'b1;
    repeat (2) @(negedge clock);
    check("badpin_to_pin", dut.state, PIN);
    check("badpin_pincount", dut.pin_count, 0);
    for (int i = 0; i < 4; i++) press_check(vecs[i].key, vecs[i].kind, vecs[i].data, vecs[i].st);
    press_check(4'd5, 1, 5, PIN);
    check("retry_pincount", dut.pin_count, 1);
    press_check(4'd2, 1, 2, PIN);
    press_check(4'd3, 1, 3, PIN);
    press_check(4'd4, 1, 4, SELECT);
    press_check(KEY_DEPOSIT, 2, 0, AMOUNT);
    press_check(4'd3, 0, 0, AMOUNT);

    // block rises on the same edge that the E key event reaches the FSM
    n_amt = 0; keyCode = KEY_ENTER; keyPressed = 1'b1;
    for (int t = 0; t < D + 4; t++) begin
      if (t == 5) block = 1'b1;
      @(negedge clock);
    end
    keyPressed = 1'b0;
    repeat (D + 4) @(negedge clock);
    check("block_no_amount", n_amt, 0);
    check("block_locked", panelLocked, 1);
    check("block_state", dut.state, LOCKED);
    press_check(4'd1, 0, 0, LOCKED);
    cardPresent = 1'b0;
    block = 1'b0;
    incorrectPin = 1'b0;
    @(negedge clock);
    check("unlock_state", dut.state, IDLE);
    check("unlock_locked", panelLocked, 0);
    check("unlock_pincount", dut.pin_count, 0);
    cardPresent = 1'b1;
    repeat (2) @(negedge clock);

    // Async reset mid-entry with a key still held
    press_check(4'd1, 1, 1, PIN);
    keyCode = 4'd8; keyPressed = 1'b1;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_digit", digit, 0);
    check("arst_amount", amount, 0);
    check("arst_transType", transType, 0);
    check("arst_state", dut.state, IDLE);
    @(negedge clock);
    reset = 1'b0;
    n_dig = 0;
    repeat (20) @(negedge clock);
    check("held_no_event", n_dig, 0);
    keyPressed = 1'b0;
    repeat (D + 4) @(negedge clock);
    press_check(4'd6, 1, 6, PIN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atm_keypad_tx.md
Name: atm_keypad_tx

Overview:
- Front-panel transmitter that drives the ATM controller's strobe interface.
- Debounces raw keypad presses and sequences them through a session FSM.
- Emits single-cycle stbDigit, stbTransaction and stbAmount pulses with their data.
- Watches the controller's status outputs to know when to restart PIN entry or lock the panel.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a press or release (min 1).
- PIN_DIGITS, 4, digits forwarded before the PIN phase closes.
- AMOUNT_DIGITS, 9, maximum decimal digits accumulated into amount (9 keeps the value below 2^32).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cardPresent  in  1  card sensor level; same meaning as the controller's receivedCard.
- keyPressed  in  1  raw key-down level, may bounce.
- keyCode  in  4  raw key code: 0-9 digits, A withdraw, B deposit, C clear, E enter; others ignored.
- incorrectPin  in  1  controller status, sticky.
- warning  in  1  controller status, sticky.
- block  in  1  controller status, sticky.
- balanceUpdated  in  1  controller status.
- insufficientFunds  in  1  controller status.
- stbDigit  out  1  one-cycle PIN digit strobe.
- digit  out  4  PIN digit, valid with stbDigit and held afterwards.
- stbTransaction  out  1  one-cycle transaction-select strobe.
- transType  out  1  1 = withdrawal, 0 = deposit; held after the strobe.
- stbAmount  out  1  one-cycle amount strobe.
- amount  out  32  binary amount; held until the next stbAmount.
- panelLocked  out  1  high while in LOCKED.

Behaviour:
- Reset: all outputs 0, state IDLE, counters and accumulator cleared, debouncer idle.
- Debouncer:
  - A press is accepted after keyPressed has been sampled high for DEBOUNCE_CYCLES consecutive cycles.
  - keyCode is captured on that final sample.
  - Exactly one key event per press.
  - The next press is accepted only after keyPressed has been low for DEBOUNCE_CYCLES consecutive cycles.
  - The key event is a one-cycle internal pulse on the edge after acceptance.
  - Any resulting strobe appears on the following edge. Fixed latency from first stable-high sample to strobe: DEBOUNCE_CYCLES+1 cycles.
- Strobes are registered, mutually exclusive, and never asserted in back-to-back cycles.
- cardPresent low in any state: IDLE on the next edge, counters and accumulator cleared, no strobe that cycle. This has priority over everything else.
- Status edges: rising edges of incorrectPin, warning and block are detected using registered copies. The copies are cleared in IDLE.
- States and transitions:
  - IDLE: cardPresent high -> PIN, pinCount=0. Key events are discarded.
  - PIN:
    - Digit key: drive digit, pulse stbDigit, pinCount+1. When pinCount reaches PIN_DIGITS -> SELECT.
    - C: pinCount=0, no strobe.
    - A, B, E: ignored.
  - SELECT:
    - A: transType=1, pulse stbTransaction -> AMOUNT.
    - B: transType=0, pulse stbTransaction -> AMOUNT.
    - Digit key: treated as the first digit of a re-entered PIN. stbDigit is pulsed, pinCount=1, -> PIN. This covers retries when status flags are already high.
    - Rising edge of incorrectPin or warning: -> PIN, pinCount=0.
  - AMOUNT:
    - Digit key while amtCount<AMOUNT_DIGITS: acc = acc*10 + d (32-bit, no overflow by construction), amtCount+1. Digit key when amtCount==AMOUNT_DIGITS: ignored.
    - C: acc=0, amtCount=0.
    - E with amtCount>0: amount<=acc, pulse stbAmount, -> RESULT.
    - E with amtCount==0: ignored.
  - RESULT: balanceUpdated or insufficientFunds high -> PIN with pinCount=0 and acc cleared. Key events are discarded.
  - LOCKED: panelLocked=1, all keys discarded. Left only via cardPresent low.
- block rising edge in PIN, SELECT, AMOUNT or RESULT: -> LOCKED. This takes priority over a same-cycle key event, whose strobe is suppressed.
- A key event coinciding with a state change caused by a status edge is discarded.
- Reset asserted mid-press or mid-entry: immediate return to reset values. A key still held when reset deasserts must be released (debounced) before it can count as a press.

Decomposition:
- Package atm_keypad_pkg:
  - key-code constants (KEY_WITHDRAW=4'hA, KEY_DEPOSIT=4'hB, KEY_CLEAR=4'hC, KEY_ENTER=4'hE);
  - state encoding for IDLE, PIN, SELECT, AMOUNT, RESULT, LOCKED;
  - the 32-bit amount width.
- Sub-module atm_key_debounce:
  - parameter DEBOUNCE_CYCLES;
  - inputs clock, reset, keyPressed, keyCode;
  - outputs keyEvent (1-cycle) and keyValue[3:0];
  - includes the held-at-reset release rule.
- The top level holds the FSM, counters, accumulator and status edge detectors.

Test Plan:
- Bouncy press (keyPressed toggling 1,0,1,1,1,1 with DEBOUNCE_CYCLES=4, key 7) in PIN -> exactly one stbDigit with digit=7, 5 cycles after the first of the four stable highs. A long hold produces no second strobe.
- Card inserted, keys 1,2,3,4 -> four stbDigit pulses (1,2,3,4), state SELECT. Key B -> stbTransaction with transType=0.
- AMOUNT: keys 2,5,0,C,1,0,0,E -> single stbAmount with amount=100. Then balanceUpdated=1 -> state PIN.
- AMOUNT: ten 9-key presses then E -> amount=999999999 (tenth digit ignored). E pressed with no digits -> no strobe.
- SELECT with incorrectPin rising -> PIN. Digit 5 pressed in SELECT while incorrectPin is held high -> stbDigit digit=5, pinCount=1.
- block rises during AMOUNT while key E is accepted in the same cycle -> no stbAmount, panelLocked=1. cardPresent low -> IDLE, panelLocked=0. Async reset mid-entry -> all outputs 0 immediately.
